// File: rtl/pwl_sigmoid_pipe.sv
// pwl_sigmoid_pipe
// ----------------
// Pipelined piecewise-linear sigmoid (and optional tanh) approximator for
// signed fixed-point samples.
//   sigmoid(-a) ~= (1/2 - f/4) >> n   with a = |x|, n = int(a), f = frac(a)
//   sigmoid(x)   = 1 - sigmoid(-x)    for x >= 0
//   tanh(x)      = 2*sigmoid(2x) - 1
//
// Three stages: S1 abs/split, S2 shift, S3 reflect.
//
// Handshake: a sample transfers on in_valid & in_ready, and a result on
// out_valid & out_ready. The whole pipe advances together when
// adv = !out_valid | out_ready. in_ready equals adv. While the output is
// stalled every stage holds. Empty stages travel as bubbles.
//
// Optional macro TANH_EN adds the per-sample mode input (0 sigmoid,
// 1 tanh). Without it the block is sigmoid-only.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input sample valid
//   in_ready   block accepts a sample this cycle
//   in_data    signed sample, FRAC_W fractional bits
//   mode       0 = sigmoid, 1 = tanh (TANH_EN only)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   result, FRAC_W fractional bits
//   out_sat    result is a saturated endpoint (h == 0 or input clamped)
module pwl_sigmoid_pipe #(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
`ifdef TANH_EN
    input  logic              mode,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
);

    // Magnitude width (sign removed) and integer-part width.
    localparam int AW = IN_W - 1;
    localparam int NW = IN_W - 1 - FRAC_W;

    localparam logic [AW-1:0]     A_MAX = {AW{1'b1}};
    localparam logic [AW-1:0]     A_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [FRAC_W-1:0] HALF  = {1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [FRAC_W+1:0] ONE   = {2'b01, {FRAC_W{1'b0}}};

    logic adv;

    // Stage 1 registers
    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic              s1_clamp_q, s1_clamp_d;
    logic [NW-1:0]     s1_n_q,     s1_n_d;
    logic [FRAC_W-1:0] s1_f_q,     s1_f_d;
    // Stage 2 registers
    logic              s2_valid_q, s2_valid_d;
    logic              s2_sign_q,  s2_sign_d;
    logic              s2_clamp_q, s2_clamp_d;
    logic [FRAC_W-1:0] s2_h_q,     s2_h_d;
    logic              s2_zero_q,  s2_zero_d;
    // Output registers
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q,  out_data_d;
    logic              out_sat_q,   out_sat_d;
`ifdef TANH_EN
    logic              s1_mode_q, s1_mode_d;
    logic              s2_mode_q, s2_mode_d;
`endif

    // Combinational intermediates
    logic [AW-1:0]     abs_a;
    logic              clamp_a;
    logic [FRAC_W-1:0] g_v;
    logic [FRAC_W-1:0] h_v;
    logic [FRAC_W+1:0] h_ext;
    logic [FRAC_W+1:0] res_v;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // S1: exact magnitude. |x| < 2^AW for every x except the most negative
    // value, so the low AW bits of the two's-complement negation suffice.
    always_comb begin
        abs_a   = in_data[IN_W-1] ? (~in_data[AW-1:0] + A_ONE) : in_data[AW-1:0];
        clamp_a = 1'b0;
        if (in_data[IN_W-1] && (in_data[AW-1:0] == '0)) begin
            abs_a   = A_MAX;
            clamp_a = 1'b1;
        end
`ifdef TANH_EN
        // tanh works on sigmoid(2x); double with saturation.
        if (mode) begin
            if (abs_a[AW-1]) begin
                abs_a   = A_MAX;
                clamp_a = 1'b1;
            end else begin
                abs_a = {abs_a[AW-2:0], 1'b0};
            end
        end
`endif
    end

    // S2: h = (1/2 - f/4) >> n, forced to zero once the shift empties g.
    always_comb begin
        g_v = HALF - (s1_f_q >> 2);
        if (int'(s1_n_q) >= FRAC_W) begin
            h_v = '0;
        end else begin
            h_v = g_v >> s1_n_q;
        end
    end

    // S3: reflect about 1/2 (sigmoid) or scale and reflect about 0 (tanh).
    always_comb begin
        h_ext = {2'b00, s2_h_q};
        res_v = s2_sign_q ? h_ext : (ONE - h_ext);
`ifdef TANH_EN
        if (s2_mode_q) begin
            res_v = s2_sign_q ? ((h_ext << 1) - ONE) : (ONE - (h_ext << 1));
        end
`endif
    end

    // Next-state: every stage loads on adv, otherwise holds.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_clamp_d  = s1_clamp_q;
        s1_n_d      = s1_n_q;
        s1_f_d      = s1_f_q;
        s2_valid_d  = s2_valid_q;
        s2_sign_d   = s2_sign_q;
        s2_clamp_d  = s2_clamp_q;
        s2_h_d      = s2_h_q;
        s2_zero_d   = s2_zero_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
`ifdef TANH_EN
        s1_mode_d   = s1_mode_q;
        s2_mode_d   = s2_mode_q;
`endif
        if (adv) begin
            s1_valid_d  = in_valid;
            s1_sign_d   = in_data[IN_W-1];
            s1_clamp_d  = clamp_a;
            s1_n_d      = abs_a[AW-1:FRAC_W];
            s1_f_d      = abs_a[FRAC_W-1:0];
            s2_valid_d  = s1_valid_q;
            s2_sign_d   = s1_sign_q;
            s2_clamp_d  = s1_clamp_q;
            s2_h_d      = h_v;
            s2_zero_d   = (h_v == '0);
            out_valid_d = s2_valid_q;
            out_data_d  = OUT_W'(res_v);
            out_sat_d   = s2_zero_q || s2_clamp_q;
`ifdef TANH_EN
            s1_mode_d   = mode;
            s2_mode_d   = s1_mode_q;
            // tanh results are signed; sigmoid results stay zero-extended.
            if (s2_mode_q) begin
                out_data_d = OUT_W'($signed(res_v));
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_clamp_q  <= 1'b0;
            s1_n_q      <= '0;
            s1_f_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_clamp_q  <= 1'b0;
            s2_h_q      <= '0;
            s2_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
`ifdef TANH_EN
            s1_mode_q   <= 1'b0;
            s2_mode_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_clamp_q  <= s1_clamp_d;
            s1_n_q      <= s1_n_d;
            s1_f_q      <= s1_f_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_clamp_q  <= s2_clamp_d;
            s2_h_q      <= s2_h_d;
            s2_zero_q   <= s2_zero_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
`ifdef TANH_EN
            s1_mode_q   <= s1_mode_d;
            s2_mode_q   <= s2_mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_pwl_sigmoid_pipe.sv
// Testbench for pwl_sigmoid_pipe (Q8.8: IN_W=16, FRAC_W=8, OUT_W=16).
// Directed samples carry table expectations; random samples use an integer
// reference model of the approximation. A negedge monitor scoreboards every
// output transfer, the in_ready rule, stall stability and 3-cycle latency.
module tb_pwl_sigmoid_pipe;
  localparam int IN_W   = 16;
  localparam int FRAC_W = 8;
  localparam int OUT_W  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  pwl_sigmoid_pipe #(.IN_W(IN_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef TANH_EN
    .mode     (mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: plain integer arithmetic on the approximation rules.
  // Returns {sat, result[15:0]}.
  function automatic logic [16:0] model(input logic [15:0] x, input logic m);
    int xi, a, n, f, g, h, r;
    bit clamp;
    clamp = 0;
    xi = int'($signed(x));
    if (xi == -32768) begin a = 32767; clamp = 1; end
    else if (xi < 0) a = -xi;
    else a = xi;
    if (m) begin
      a = a * 2;
      if (a > 32767) begin a = 32767; clamp = 1; end
    end
    n = a / 256;
    f = a % 256;
    g = 128 - f / 4;
    h = (n >= 8) ? 0 : g / (1 << n);
    if (!m) r = (xi < 0) ? h : 256 - h;
    else    r = (xi < 0) ? 2 * h - 256 : 256 - 2 * h;
    return {(h == 0) || clamp, r[15:0]};
  endfunction

  // scoreboard
  logic [16:0] exp_q[$];
  logic        use_tab = 0;
  logic [16:0] tab_exp = '0;
  int          cyc = 0;
  bit          chk_lat = 0;
  int          lat_start = 0;
  bit          acc_hist[64];
  bit          stall_seen = 0;
  logic [16:0] held = '0;
  logic        mode_eff;

`ifdef TANH_EN
  assign mode_eff = mode;
`else
  assign mode_eff = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst) begin
      check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (stall_seen && out_valid) check("stall_hold", {15'b0, out_sat, out_data}, {15'b0, held});
      stall_seen = out_valid && !out_ready;
      held = {out_sat, out_data};
      acc_hist[cyc % 64] = in_valid && in_ready;
      if (chk_lat && cyc >= lat_start + 3)
        check("valid_latency", {31'b0, out_valid}, {31'b0, acc_hist[(cyc - 3) % 64]});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {31'b0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {16'b0, out_data}, {16'b0, e[15:0]});
          check("out_sat", {31'b0, out_sat}, {31'b0, e[16]});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(use_tab ? tab_exp : model(in_data, mode_eff));
    end else begin
      stall_seen = 0;
    end
  end

  // driver tasks: called right after a rising edge, return #1 after the
  // edge that accepted the sample.
  task automatic send(input logic [15:0] x, input logic m);
    int t = 0;
    in_valid = 1'b1;
    in_data  = x;
    mode     = m;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("send_timeout", t, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [15:0] x, input logic m, input logic [16:0] ex);
    use_tab = 1;
    tab_exp = ex;
    send(x, m);
    use_tab = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    idle(2);
  endtask

  bit rnd_done;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    check("rst_out_sat", {31'b0, out_sat}, 32'd0);
    #20 rst = 1'b0;
    idle(1);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: sigmoid sweep, back-to-back, latency tracked
    chk_lat = 1; lat_start = cyc;
    send_exp(16'h0000, 1'b0, {1'b0, 16'h0080});
    send_exp(16'h0100, 1'b0, {1'b0, 16'h00C0});
    send_exp(16'hFF00, 1'b0, {1'b0, 16'h0040});
    send_exp(16'h0080, 1'b0, {1'b0, 16'h00A0});
    // 2: extremes
    send_exp(16'h7FFF, 1'b0, {1'b1, 16'h0100});
    send_exp(16'h8000, 1'b0, {1'b1, 16'h0000});
    send_exp(16'h0700, 1'b0, {1'b0, 16'h00FF});
    send_exp(16'h0800, 1'b0, {1'b1, 16'h0100});
    drain();

    // 6: bubbles 1,0,1,0
    lat_start = cyc;
    for (int i = 0; i < 4; i++) begin
      send(16'($urandom_range(0, 65535)), 1'b0);
      idle(1);
    end
    drain();
    chk_lat = 0;

    // 3: backpressure mid-stream
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'($urandom_range(0, 65535)), 1'b0);
      end
      begin
        idle(4);
        out_ready = 1'b0;
        idle(4);
        out_ready = 1'b1;
      end
    join
    drain();

    // 4: async reset mid-cycle with samples in flight
    for (int i = 0; i < 3; i++) send(16'($urandom_range(0, 65535)), 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_data", {16'b0, out_data}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    idle(1);
    chk_lat = 1; lat_start = cyc;
    send_exp(16'h0100, 1'b0, {1'b0, 16'h00C0});
    drain();
    chk_lat = 0;

`ifdef TANH_EN
    // 5: tanh mixed with sigmoid back-to-back
    chk_lat = 1; lat_start = cyc;
    send_exp(16'h0080, 1'b1, {1'b0, 16'h0080});
    send_exp(16'h0080, 1'b0, {1'b0, 16'h00A0});
    send_exp(16'hFF80, 1'b1, {1'b0, 16'hFF80});
    send_exp(16'h0000, 1'b1, {1'b0, 16'h0000});
    send_exp(16'h0080, 1'b0, {1'b0, 16'h00A0});
    drain();
    chk_lat = 0;
`endif

    // random traffic with random backpressure
    rnd_done = 0;
    fork
      begin
        logic [15:0] x;
        logic        m;
        for (int i = 0; i < 250; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          case ($urandom_range(0, 7))
            0: x = 16'h8000;
            1: x = 16'h7FFF;
            2: x = 16'($urandom_range(0, 4095)) - 16'd2048;
            default: x = 16'($urandom_range(0, 65535));
          endcase
`ifdef TANH_EN
          m = 1'($urandom_range(0, 1));
`else
          m = 1'b0;
`endif
          send(x, m);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          idle(1);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // absolute time limit
  initial begin
    #200000;
    check("global_timeout", 1'b0 + n_checks, 32'hFFFFFFFF);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
